// File: rtl/unpool_stream_if.sv
// rtl/unpool_stream_if.sv - pooled-input / upsampled-output stream handshake bundle
interface unpool_stream_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/unpool_stream.sv
// rtl/unpool_stream.sv - 2x nearest-neighbour upsampler buffering one pooled frame
module unpool_stream #(
  parameter int DW = 8,
  parameter int PC = 3,
  parameter int PH = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  unpool_stream_if.slave  s,
  output logic            busy
);

  localparam int N  = PC * PH * PH;
  localparam int W  = 2 * PH;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (PC > 1) ? $clog2(PC) : 1;
  localparam int XW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {LOAD, EMIT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [XW-1:0] y_q, y_d;
  logic [XW-1:0] x_q, x_d;

  logic [DW-1:0] buf_q [N];

  logic          emit;
  logic          in_hs;
  logic          out_hs;
  logic          last;
  logic [AW-1:0] rd_idx;

  assign emit   = (state_q == EMIT);
  assign in_hs  = !emit && s.in_valid;
  assign out_hs = emit && s.out_ready;
  assign last   = emit && (ch_q == CW'(PC - 1)) && (y_q == XW'(W - 1)) && (x_q == XW'(W - 1));

  // Each pooled element covers a 2x2 output block, so drop the LSB of y and x.
  assign rd_idx = (AW'(ch_q) * AW'(PH) + AW'(y_q >> 1)) * AW'(PH) + AW'(x_q >> 1);

  assign s.in_ready  = !emit;
  assign s.out_valid = emit;
  assign s.out_last  = last;
  assign s.out_data  = emit ? buf_q[rd_idx] : '0;
  assign busy        = emit;

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    ch_d     = ch_q;
    y_d      = y_q;
    x_d      = x_q;
    case (state_q)
      LOAD: begin
        if (in_hs) begin
          if (wr_cnt_q == AW'(N - 1)) begin
            wr_cnt_d = '0;
            ch_d     = '0;
            y_d      = '0;
            x_d      = '0;
            state_d  = EMIT;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_hs) begin
          if (x_q == XW'(W - 1)) begin
            x_d = '0;
            if (y_q == XW'(W - 1)) begin
              y_d = '0;
              if (ch_q == CW'(PC - 1)) begin
                ch_d    = '0;
                state_d = LOAD;
              end else begin
                ch_d = ch_q + 1'b1;
              end
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      wr_cnt_q <= '0;
      ch_q     <= '0;
      y_q      <= '0;
      x_q      <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      ch_q     <= ch_d;
      y_q      <= y_d;
      x_q      <= x_d;
    end
  end

  // Frame storage is never read outside EMIT, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      buf_q[wr_cnt_q] <= s.in_data;
    end
  end

endmodule

// File: doc/unpool_stream.md
UNPOOL_STREAM -- requirements
Module: unpool_stream

Interface
REQ-001 Parameter DW, default 8: element width in bits, unsigned.
REQ-002 Parameter PC, default 3: channels per frame.
REQ-003 Parameter PH, default 3: pooled map height and width (square); the upsampled map is 2*PH x 2*PH.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_data holds a valid pooled element.
REQ-007 in_ready  output  1  block accepts an element this cycle.
REQ-008 in_data  input  DW  pooled element, frame order index (ch*PH+r)*PH+c, ch outermost, c innermost.
REQ-009 out_valid  output  1  out_data holds a valid upsampled element.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  DW  upsampled element, order index (ch*2PH+y)*2PH+x.
REQ-012 out_last  output  1  high with the final element (index PC*4*PH*PH-1) of a frame.
REQ-013 busy  output  1  high while in EMIT.

Function
REQ-014 The block SHALL perform 2x nearest-neighbour upsampling: out[ch][y][x] = in[ch][y>>1][x>>1], values copied unchanged, no arithmetic.
REQ-015 The block SHALL buffer one full pooled frame (PC*PH*PH elements, 27 by default) in internal registers before emitting.
REQ-016 There SHALL be exactly two states: LOAD and EMIT.
REQ-017 In LOAD, in_ready SHALL be 1 and out_valid 0; each cycle with in_valid&in_ready SHALL write in_data to slot wr_cnt and increment wr_cnt.
REQ-018 The handshake accepting slot PC*PH*PH-1 SHALL move the state to EMIT at that edge, clear wr_cnt, and load the output counters (ch,y,x)=(0,0,0).
REQ-019 In EMIT, in_ready SHALL be 0; input data is ignored.
REQ-020 out_valid SHALL be 1 in every EMIT cycle; out_data and out_last SHALL be combinational selections of the buffer by the current (ch,y,x) and SHALL remain stable while out_ready is 0.
REQ-021 First out_valid SHALL appear in the cycle immediately after the last input handshake (latency 1 cycle).
REQ-022 Each out_valid&out_ready handshake SHALL advance x; x wraps from 2PH-1 to 0 and increments y; y wraps from 2PH-1 to 0 and increments ch.
REQ-023 out_last SHALL be 1 only when ch=PC-1, y=2PH-1 and x=2PH-1 in EMIT.
REQ-024 The handshake with out_last=1 SHALL return the state to LOAD; in_ready SHALL be 1 in the next cycle (one-cycle turnaround, no frame overlap).
REQ-025 A full frame of PC*4*PH*PH outputs (108 by default) SHALL take exactly 108 cycles with out_ready held at 1.
REQ-026 in_valid deasserted during LOAD SHALL stall loading with no change of wr_cnt or buffer contents.
REQ-027 Counters SHALL be sized to hold their maximum value without overflow; no counter SHALL exceed its wrap limit.
REQ-028 busy SHALL equal (state==EMIT).

Reset
REQ-029 On rst_n=0, asynchronously: state=LOAD, wr_cnt=0, (ch,y,x)=(0,0,0), out_valid=0, out_last=0, busy=0, in_ready=1 after release.
REQ-030 Buffer contents SHALL NOT require reset; out_data SHALL read 0 whenever out_valid=0.
REQ-031 Reset during LOAD or EMIT SHALL discard the partial frame; the next frame starts at slot 0.

Verification
REQ-032 Load in_data=0..26 with in_valid held at 1, out_ready=1 -> first outputs 0,0,1,1,2,2 (row y=0), second row identical, out[36]=9, out_last on output 107 with value 26, exactly 108 cycles.
REQ-033 Same frame with out_ready toggling 1,0 each cycle -> output sequence identical, out_data stable during stalls, 216 cycles to drain.
REQ-034 Two back-to-back frames (0..26, then 100..126) -> in_ready=0 for 108 cycles, then 1 for exactly the cycle after out_last; second frame first output = 100.
REQ-035 in_valid with gaps (every third cycle 0) -> 27 elements captured correctly; EMIT entered after the 27th handshake only.
REQ-036 Assert rst_n=0 after 50 outputs -> out_valid=0 immediately; after release a new frame 200..226 gives first output 200.
REQ-037 Reference-model check: 100 random frames compared against out[ch][y][x]=in[ch][y>>1][x>>1] -> zero mismatches.
